// File: rtl/tetris_board_writer_if.sv
// Lock-request / board-contents bundle between the game controller (master)
// and the board writer (slave); the renderer taps grid.
interface tetris_board_writer_if #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int COLOR_W = 4
);
  logic                                    clear_board;
  logic                                    lock_valid;
  logic                                    lock_ready;
  logic [3:0]                              piece_type;
  logic [1:0]                              piece_rot;
  logic signed [4:0]                       piece_x;
  logic signed [5:0]                       piece_y;
  logic [0:ROWS-1][0:COLS-1][COLOR_W-1:0]  grid;
  logic                                    busy;
  logic                                    done;
  logic [2:0]                              lines_cleared;
  logic                                    top_out;
  logic [19:0]                             score;

  modport master (
    output clear_board, lock_valid, piece_type, piece_rot, piece_x, piece_y,
    input  lock_ready, grid, busy, done, lines_cleared, top_out, score
  );

  modport slave (
    input  clear_board, lock_valid, piece_type, piece_rot, piece_x, piece_y,
    output lock_ready, grid, busy, done, lines_cleared, top_out, score
  );
endinterface

// File: rtl/tetris_board_writer.sv
// Playfield owner: merges a locked piece into the grid, then collapses full rows.
// Optional scoring is built only when BOARD_SCORE_EN is defined.
module tetris_board_writer #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int COLOR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tetris_board_writer_if.slave bus
);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, MERGE, SCAN, SHIFT, DONE} state_t;

  // Rotations packed rot3..rot0; mask bit r*4+c is box cell (row r, col c).
  function automatic logic [15:0] shape(input logic [3:0] t, input logic [1:0] r);
    logic [63:0] rots;
    case (t)
      4'd0:    rots = {16'h2222, 16'h00F0, 16'h4444, 16'h0F00};
      4'd1:    rots = {16'h44C0, 16'h0E20, 16'h6440, 16'h8E00};
      4'd2:    rots = {16'h4460, 16'h0E80, 16'hC440, 16'h2E00};
      4'd3:    rots = {16'h6600, 16'h6600, 16'h6600, 16'h6600};
      4'd4:    rots = {16'h8C40, 16'h06C0, 16'h4620, 16'h6C00};
      4'd5:    rots = {16'h4C40, 16'h0E40, 16'h4640, 16'h4E00};
      4'd6:    rots = {16'h2640, 16'h0C60, 16'h4C80, 16'hC600};
      default: rots = '0;
    endcase
    return rots[{r, 4'b0000} +: 16];
  endfunction

  state_t                                 state, state_nx;
  logic [3:0]                             p_type;
  logic [1:0]                             p_rot;
  logic signed [4:0]                      p_x;
  logic signed [5:0]                      p_y;
  logic [RW-1:0]                          row_ptr;
  logic [2:0]                             count, lines;
  logic                                   done_q, top_q;
  logic [0:ROWS-1][0:COLS-1][COLOR_W-1:0] grid_q;
  logic [15:0]                            mask;
  logic [COLOR_W-1:0]                     code;
  logic [0:ROWS-1][0:COLS-1]              hit;
  logic [0:ROWS-1]                        row_full;
  logic                                   top_hit;
  logic                                   shift_again;

  assign mask = shape(p_type, p_rot);
  assign code = COLOR_W'(p_type) + COLOR_W'(1);

  // Per-cell merge hits; cells landing above the board only raise top_hit.
  always_comb begin
    hit     = '0;
    top_hit = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r >= int'(p_y) && r < int'(p_y) + 4 && c >= int'(p_x) && c < int'(p_x) + 4)
          hit[r][c] = mask[{2'(r - int'(p_y)), 2'(c - int'(p_x))}];
    for (int r = 0; r < 4; r++)
      if (int'(p_y) + r < 0 && mask[4*r +: 4] != 4'h0)
        top_hit = 1'b1;
  end

  always_comb begin
    row_full = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (grid_q[r][c] == '0) row_full[r] = 1'b0;
  end

  // SHIFT already knows whether row r will be full again (old row r-1), so it
  // re-tests row r itself instead of spending a SCAN cycle: 1 cycle per line.
  assign shift_again = (row_ptr != '0) && row_full[row_ptr - 1'b1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.lock_valid) state_nx = MERGE;
      MERGE:   state_nx = SCAN;
      SCAN:    if (row_full[row_ptr])   state_nx = SHIFT;
               else if (row_ptr == '0)  state_nx = DONE;
      SHIFT:   if (shift_again)         state_nx = SHIFT;
               else if (row_ptr == '0)  state_nx = DONE;
               else                     state_nx = SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.clear_board) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_q  <= '0;
      p_type  <= '0;
      p_rot   <= '0;
      p_x     <= '0;
      p_y     <= '0;
      row_ptr <= '0;
      count   <= '0;
      lines   <= '0;
      done_q  <= 1'b0;
      top_q   <= 1'b0;
    end else if (bus.clear_board) begin
      grid_q  <= '0;
      count   <= '0;
      lines   <= '0;
      done_q  <= 1'b0;
      top_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.lock_valid) begin
          p_type <= bus.piece_type;
          p_rot  <= bus.piece_rot;
          p_x    <= bus.piece_x;
          p_y    <= bus.piece_y;
          count  <= '0;
        end
        MERGE: begin
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              if (hit[r][c]) grid_q[r][c] <= code;
          if (top_hit) top_q <= 1'b1;
          row_ptr <= RW'(ROWS - 1);
        end
        SCAN: if (state_nx == SCAN) row_ptr <= row_ptr - 1'b1;
        SHIFT: begin
          for (int r = 1; r < ROWS; r++)
            if (RW'(r) <= row_ptr) grid_q[r] <= grid_q[r-1];
          grid_q[0] <= '0;
          count     <= count + 3'd1;
          if (state_nx == SCAN) row_ptr <= row_ptr - 1'b1;
        end
        DONE: begin
          done_q <= 1'b1;
          lines  <= count;
        end
        default: ;
      endcase
    end
  end

`ifdef BOARD_SCORE_EN
  logic [19:0] score_q;
  logic [10:0] pts;
  logic [20:0] sum;

  always_comb begin
    pts = '0;
    case (count)
      3'd1:    pts = 11'd40;
      3'd2:    pts = 11'd100;
      3'd3:    pts = 11'd300;
      3'd4:    pts = 11'd1200;
      default: pts = '0;
    endcase
  end

  assign sum = {1'b0, score_q} + 21'(pts);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                score_q <= '0;
    else if (bus.clear_board)  score_q <= '0;
    else if (state == DONE)    score_q <= sum[20] ? 20'hFFFFF : sum[19:0];
  end

  assign bus.score = score_q;
`else
  assign bus.score = '0;
`endif

  assign bus.lock_ready    = (state == IDLE);
  assign bus.busy          = (state != IDLE);
  assign bus.grid          = grid_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lines;
  assign bus.top_out       = top_q;
endmodule

// File: tb/tb_tetris_board_writer.sv
// Directed bench for tetris_board_writer: merge, line clears, top-out, abort, request hold.
`timescale 1ns/1ps
module tb_tetris_board_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tetris_board_writer_if #(.ROWS(20), .COLS(10), .COLOR_W(4)) b ();
  tetris_board_writer #(.ROWS(20), .COLS(10), .COLOR_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  int checks = 0;
  int errors = 0;
  logic [0:19][0:9][3:0] exp_grid;

`ifdef BOARD_SCORE_EN
  localparam longint SCORE_O5 = 100;
`else
  localparam longint SCORE_O5 = 0;
`endif

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int grid_diff();
    int n = 0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        if (b.grid[r][c] !== exp_grid[r][c]) n++;
    return n;
  endfunction

  task automatic do_clear();
    @(negedge clk);
    b.clear_board = 1'b1;
    @(negedge clk);
    b.clear_board = 1'b0;
  endtask

  // Returns cycles from the accepting edge to the first sample with done high.
  task automatic do_lock(input logic [3:0] t, input logic [1:0] r, input int x, input int y,
                         input string tag, output int lat);
    @(negedge clk);
    chk({tag, "_ready"}, b.lock_ready, 1);
    b.piece_type = t;
    b.piece_rot  = r;
    b.piece_x    = 5'(x);
    b.piece_y    = 6'(y);
    b.lock_valid = 1'b1;
    @(negedge clk);
    b.lock_valid = 1'b0;
    b.piece_type = 4'd6;
    b.piece_rot  = 2'd3;
    b.piece_x    = 5'd0;
    b.piece_y    = 6'd0;
    lat = 0;
    while (!b.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, dn, dk, na, w;
    int acc [4];
    b.clear_board = 1'b0;
    b.lock_valid  = 1'b0;
    b.piece_type  = '0;
    b.piece_rot   = '0;
    b.piece_x     = '0;
    b.piece_y     = '0;
    exp_grid      = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_grid", grid_diff(), 0);
    chk("rst_ready", b.lock_ready, 1);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.done, 0);
    chk("rst_top", b.top_out, 0);
    chk("rst_score", b.score, 0);
    chk("rst_lines", b.lines_cleared, 0);

    // I piece on an empty board
    do_lock(4'd0, 2'd0, 3, 17, "i", lat);
    for (int c = 3; c <= 6; c++) exp_grid[19][c] = 4'd1;
    chk("i_lat", lat, 22);
    chk("i_lines", b.lines_cleared, 0);
    chk("i_grid", grid_diff(), 0);

    do_clear();
    exp_grid = '0;
    chk("clr_grid", grid_diff(), 0);

    // Five O pieces filling rows 18..19
    do_lock(4'd3, 2'd0, -1, 16, "o1", lat);
    chk("o1_lat", lat, 22);
    do_lock(4'd3, 2'd0, 1, 16, "o2", lat);
    do_lock(4'd3, 2'd0, 3, 16, "o3", lat);
    do_lock(4'd3, 2'd0, 5, 16, "o4", lat);
    chk("o4_lat", lat, 22);
    chk("o4_lines", b.lines_cleared, 0);
    for (int r = 18; r <= 19; r++)
      for (int c = 0; c <= 7; c++) exp_grid[r][c] = 4'd4;
    chk("o4_grid", grid_diff(), 0);
    do_lock(4'd3, 2'd0, 7, 16, "o5", lat);
    exp_grid = '0;
    chk("o5_lat", lat, 24);
    chk("o5_lines", b.lines_cleared, 2);
    chk("o5_grid", grid_diff(), 0);
    chk("o5_score", b.score, SCORE_O5);

    // Abort a lock mid-scan
    @(negedge clk);
    b.piece_type = 4'd3; b.piece_rot = 2'd0; b.piece_x = 5'sd3; b.piece_y = 6'sd16;
    b.lock_valid = 1'b1;
    @(negedge clk);
    b.lock_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", b.busy, 1);
    b.clear_board = 1'b1;
    @(negedge clk);
    chk("abort_busy", b.busy, 0);
    chk("abort_ready", b.lock_ready, 1);
    chk("abort_grid", grid_diff(), 0);
    chk("abort_lines", b.lines_cleared, 0);
    chk("abort_score", b.score, 0);
    b.clear_board = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (b.done) dn++;
    end
    chk("abort_nodone", dn, 0);

    // T piece poking above the top
    do_lock(4'd5, 2'd0, 0, -3, "t", lat);
    exp_grid[0][2] = 4'd6;
    chk("t_lat", lat, 22);
    chk("t_top", b.top_out, 1);
    chk("t_grid", grid_diff(), 0);

    do_lock(4'd3, 2'd0, 3, 16, "o6", lat);
    for (int r = 18; r <= 19; r++)
      for (int c = 4; c <= 5; c++) exp_grid[r][c] = 4'd4;
    chk("o6_grid", grid_diff(), 0);
    chk("o6_top", b.top_out, 1);

    // Invalid type: no writes, normal latency
    do_lock(4'd9, 2'd0, 0, 0, "inv", lat);
    chk("inv_lat", lat, 22);
    chk("inv_grid", grid_diff(), 0);

    // Column overflow on the right, then rows below the floor
    do_lock(4'd0, 2'd0, 8, -2, "iright", lat);
    exp_grid[0][8] = 4'd1;
    exp_grid[0][9] = 4'd1;
    chk("iright_grid", grid_diff(), 0);
    do_lock(4'd3, 2'd0, 0, 18, "ofloor", lat);
    chk("ofloor_grid", grid_diff(), 0);
    chk("ofloor_top", b.top_out, 1);

    do_clear();
    exp_grid = '0;
    chk("clr2_top", b.top_out, 0);
    chk("clr2_grid", grid_diff(), 0);

    // lock_valid held high for 30 cycles
    @(negedge clk);
    b.piece_type = 4'd0; b.piece_rot = 2'd0; b.piece_x = 5'sd3; b.piece_y = 6'sd17;
    b.lock_valid = 1'b1;
    dn = 0; dk = -1; na = 0;
    for (int k = 0; k < 30; k++) begin
      if (b.lock_ready && na < 4) begin
        acc[na] = k;
        na++;
      end
      @(negedge clk);
      if (b.done) begin
        dn++;
        dk = k;
      end
    end
    b.lock_valid = 1'b0;
    chk("hold_dones", dn, 1);
    chk("hold_done_at", dk, 22);
    chk("hold_accepts", na, 2);
    if (na >= 2) chk("hold_acc2_at", acc[1], 23);
    w = 0;
    while (!b.done && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("hold_done2", b.done, 1);
    for (int c = 3; c <= 6; c++) exp_grid[19][c] = 4'd1;
    chk("hold_grid", grid_diff(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end
endmodule
